// File: rtl/dllp_tlp_arb.sv
// Packet arbiter merging a DLLP and a TLP AXI-Stream source onto one output stream.
// Optional DLLP_TLP_ARB_FAIRNESS_EN adds a starvation counter bounding consecutive DLLP grants.
module dllp_tlp_arb #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 2,
    parameter int MAX_DLLP_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            link_status_i,

    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,

    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic                  busy_o
);

    // Data link status encoding: 0 inactive, 1 feature exchange, 2 init, 3 active.
    localparam logic [1:0] DL_ACTIVE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TLP  = 2'd1;
    localparam logic [1:0] ST_DLLP = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       tlp_elig;
    logic       dllp_elig;
    logic       tlp_forced;
    logic       arb_en;
    logic       grant_tlp;
    logic       grant_dllp;
    logic       sel_tlp;
    logic       sel_dllp;
    logic       hs_last;

    assign tlp_elig  = s_tlp_axis_tvalid && (link_status_i == DL_ACTIVE);
    assign dllp_elig = s_dllp_axis_tvalid;

    // While reset is held the arbiter stays idle; the first grant lands in the first low cycle.
    assign arb_en     = (state == ST_IDLE) && !rst_i;
    assign grant_tlp  = arb_en && tlp_elig && (tlp_forced || !dllp_elig);
    assign grant_dllp = arb_en && dllp_elig && !grant_tlp;

    assign sel_tlp  = grant_tlp  || (state == ST_TLP);
    assign sel_dllp = grant_dllp || (state == ST_DLLP);

`ifdef DLLP_TLP_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_DLLP_BURST + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign tlp_forced = tlp_elig && (starve_cnt == CNT_W'(MAX_DLLP_BURST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_tlp || !tlp_elig) begin
                starve_cnt <= '0;
            end else if (grant_dllp) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign tlp_forced = 1'b0;
`endif

    always_comb begin
        m_axis_tdata       = '0;
        m_axis_tkeep       = '0;
        m_axis_tvalid      = 1'b0;
        m_axis_tlast       = 1'b0;
        m_axis_tuser       = '0;
        s_tlp_axis_tready  = 1'b0;
        s_dllp_axis_tready = 1'b0;
        if (sel_tlp) begin
            m_axis_tdata      = s_tlp_axis_tdata;
            m_axis_tkeep      = s_tlp_axis_tkeep;
            m_axis_tvalid     = s_tlp_axis_tvalid;
            m_axis_tlast      = s_tlp_axis_tlast;
            m_axis_tuser      = s_tlp_axis_tuser;
            m_axis_tuser[1:0] = 2'b10;
            s_tlp_axis_tready = m_axis_tready;
        end else if (sel_dllp) begin
            m_axis_tdata       = s_dllp_axis_tdata;
            m_axis_tkeep       = s_dllp_axis_tkeep;
            m_axis_tvalid      = s_dllp_axis_tvalid;
            m_axis_tlast       = s_dllp_axis_tlast;
            m_axis_tuser       = s_dllp_axis_tuser;
            m_axis_tuser[1:0]  = 2'b01;
            s_dllp_axis_tready = m_axis_tready;
        end
    end

    assign hs_last = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Link status is only looked at when granting, so a TLP already in flight always completes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_tlp && !hs_last) begin
                    state_next = ST_TLP;
                end else if (grant_dllp && !hs_last) begin
                    state_next = ST_DLLP;
                end
            end
            ST_TLP, ST_DLLP: begin
                if (hs_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_dllp_tlp_arb.sv
// Scoreboard bench for dllp_tlp_arb: directed packets, expected beats queued, monitor compares.
module tb_dllp_tlp_arb;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 2;
    localparam int EW = DW + KW + 1 + UW;

    logic          clk;
    logic          rst;
    logic [1:0]    link;
    logic [DW-1:0] tlp_data;
    logic [KW-1:0] tlp_keep;
    logic          tlp_valid;
    logic          tlp_last;
    logic [UW-1:0] tlp_user;
    logic          tlp_ready;
    logic [DW-1:0] dllp_data;
    logic [KW-1:0] dllp_keep;
    logic          dllp_valid;
    logic          dllp_last;
    logic [UW-1:0] dllp_user;
    logic          dllp_ready;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic          m_valid;
    logic          m_last;
    logic [UW-1:0] m_user;
    logic          m_ready;
    logic          busy;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    int            c0;

    dllp_tlp_arb dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .link_status_i      (link),
        .s_tlp_axis_tdata   (tlp_data),
        .s_tlp_axis_tkeep   (tlp_keep),
        .s_tlp_axis_tvalid  (tlp_valid),
        .s_tlp_axis_tlast   (tlp_last),
        .s_tlp_axis_tuser   (tlp_user),
        .s_tlp_axis_tready  (tlp_ready),
        .s_dllp_axis_tdata  (dllp_data),
        .s_dllp_axis_tkeep  (dllp_keep),
        .s_dllp_axis_tvalid (dllp_valid),
        .s_dllp_axis_tlast  (dllp_last),
        .s_dllp_axis_tuser  (dllp_user),
        .s_dllp_axis_tready (dllp_ready),
        .m_axis_tdata       (m_data),
        .m_axis_tkeep       (m_keep),
        .m_axis_tvalid      (m_valid),
        .m_axis_tlast       (m_last),
        .m_axis_tuser       (m_user),
        .m_axis_tready      (m_ready),
        .busy_o             (busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] beat(input logic [31:0] d, input logic l, input logic [1:0] u);
        return {d, 4'hf, l, u};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: presents n beats on one source and waits for each source handshake.
    task automatic drive(input bit is_tlp, input int n, input logic [31:0] base, input logic [1:0] user);
        for (int i = 0; i < n; i++) begin
            int t;
            if (is_tlp) begin
                tlp_data = base + i; tlp_keep = 4'hf; tlp_last = (i == n - 1);
                tlp_user = user; tlp_valid = 1'b1;
            end else begin
                dllp_data = base + i; dllp_keep = 4'hf; dllp_last = (i == n - 1);
                dllp_user = user; dllp_valid = 1'b1;
            end
            t = 0;
            @(negedge clk);
            while (!(is_tlp ? tlp_ready : dllp_ready) && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL handshake_timeout: source %0d beat %0d got no tready within 200 cycles", is_tlp, i);
            end
            step();
        end
        if (is_tlp) begin
            tlp_valid = 1'b0; tlp_last = 1'b0;
        end else begin
            dllp_valid = 1'b0; dllp_last = 1'b0;
        end
    endtask

    // Monitor: every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_beat: got %0h, expected no beat", {m_data, m_keep, m_last, m_user});
            end else begin
                mon_e = exp_q.pop_front();
                check("m_axis_beat", 64'({m_data, m_keep, m_last, m_user}), 64'(mon_e));
            end
        end
    end

    initial begin
        rst = 1'b1; link = 2'd3; m_ready = 1'b1;
        tlp_data = '0; tlp_keep = '0; tlp_valid = 1'b0; tlp_last = 1'b0; tlp_user = '0;
        dllp_data = 32'hD000_0001; dllp_keep = 4'hf; dllp_valid = 1'b1; dllp_last = 1'b1; dllp_user = 2'b00;

        // Reset state with a DLLP already waiting
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_m_tvalid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dllp_tready", dllp_ready, 0);
        check("rst_tlp_tready", tlp_ready, 0);
        exp_q.push_back(beat(32'hD000_0001, 1'b1, 2'b01));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("first_arb_m_tvalid", m_valid, 1);
        step();
        dllp_valid = 1'b0;
        step();

        // DLLP only, 2 beats: busy only on the second beat
        exp_q.push_back(beat(32'hD100_0000, 1'b0, 2'b01));
        exp_q.push_back(beat(32'hD100_0001, 1'b1, 2'b01));
        fork
            drive(1'b0, 2, 32'hD100_0000, 2'b10);
            begin
                @(negedge clk);
                check("dllp_c0_busy", busy, 0);
                check("dllp_c0_tvalid", m_valid, 1);
                @(negedge clk);
                check("dllp_c1_busy", busy, 1);
                @(negedge clk);
                check("dllp_after_busy", busy, 0);
                check("dllp_after_tvalid", m_valid, 0);
            end
        join
        step();

        // Simultaneous request: DLLP first, then the whole TLP, one idle-state cycle between
        exp_q.push_back(beat(32'hD200_0000, 1'b0, 2'b01));
        exp_q.push_back(beat(32'hD200_0001, 1'b1, 2'b01));
        for (int i = 0; i < 4; i++) exp_q.push_back(beat(32'hA200_0000 + i, i == 3, 2'b10));
        c0 = cyc;
        fork
            drive(1'b0, 2, 32'hD200_0000, 2'b00);
            drive(1'b1, 4, 32'hA200_0000, 2'b00);
        join
        check("simul_cycles", cyc - c0, 6);

        // Link not active: TLP held off until the link comes up
        link = 2'd1;
        exp_q.push_back(beat(32'hB000_0000, 1'b1, 2'b10));
        fork
            drive(1'b1, 1, 32'hB000_0000, 2'b01);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("link_down_tlp_tready", tlp_ready, 0);
                    check("link_down_m_tvalid", m_valid, 0);
                end
                step();
                link = 2'd3;
            end
        join

        // Backpressure 1010 across a 3-beat TLP; stalled beat must hold
        for (int i = 0; i < 3; i++) exp_q.push_back(beat(32'hC000_0000 + i, i == 2, 2'b10));
        fork
            drive(1'b1, 3, 32'hC000_0000, 2'b00);
            begin
                for (int c = 0; c < 5; c++) begin
                    m_ready = (c % 2 == 0);
                    if (c % 2 == 1) begin
                        @(negedge clk);
                        check("stall_tvalid", m_valid, 1);
                        check("stall_tdata", m_data, 32'hC000_0000 + (c + 1) / 2);
                    end
                    step();
                end
                m_ready = 1'b1;
            end
        join

        // Reset during beat 2 of a 4-beat TLP
        exp_q.push_back(beat(32'hE000_0000, 1'b0, 2'b10));
        exp_q.push_back(beat(32'hE000_0001, 1'b0, 2'b10));
        tlp_keep = 4'hf; tlp_user = 2'b00; tlp_last = 1'b0; tlp_valid = 1'b1;
        tlp_data = 32'hE000_0000;
        step();
        tlp_data = 32'hE000_0001;
        step();
        tlp_data = 32'hE000_0002;
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_pkt_busy", busy, 1);
        step();
        rst = 1'b0; tlp_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        check("post_rst_tvalid", m_valid, 0);
        check("post_rst_busy", busy, 0);
        step();
        exp_q.push_back(beat(32'hF000_0000, 1'b1, 2'b01));
        exp_q.push_back(beat(32'hF100_0000, 1'b1, 2'b10));
        fork
            drive(1'b0, 1, 32'hF000_0000, 2'b00);
            drive(1'b1, 1, 32'hF100_0000, 2'b00);
        join

        // Continuous DLLP with a pending TLP
        for (int i = 0; i < 10; i++) begin
`ifdef DLLP_TLP_ARB_FAIRNESS_EN
            if (i % 5 == 4) exp_q.push_back(beat(32'h7700_0000, 1'b1, 2'b10));
            else            exp_q.push_back(beat(32'h5500_0000, 1'b1, 2'b01));
`else
            exp_q.push_back(beat(32'h5500_0000, 1'b1, 2'b01));
`endif
        end
        dllp_data = 32'h5500_0000; dllp_keep = 4'hf; dllp_last = 1'b1; dllp_user = 2'b00; dllp_valid = 1'b1;
        tlp_data  = 32'h7700_0000; tlp_keep  = 4'hf; tlp_last  = 1'b1; tlp_user  = 2'b00; tlp_valid  = 1'b1;
        repeat (10) step();
        dllp_valid = 1'b0;
        tlp_valid = 1'b0;

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
